// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-Lite arbiter.
// One transaction at a time, grant held until the response handshake, with bounded IFU starvation.
module ysyx_24100006_axi_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,

    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,

    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_RD,
        S_LS_RD,
        S_LS_WR
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       aw_done;
    logic       w_done;
    logic       ifu_starved;
    logic [3:0] starve_next;

    assign ifu_starved = ifu_arvalid && (starve_cnt == LIMIT);
    assign starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;

    // Losses are only counted while the IFU is actually waiting; an IFU win clears the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            starve_cnt <= 4'd0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ifu_starved) begin
                        state      <= S_IF_RD;
                        starve_cnt <= 4'd0;
                    end else if (lsu_awvalid) begin
                        state <= S_LS_WR;
                        if (ifu_arvalid) starve_cnt <= starve_next;
                    end else if (lsu_arvalid) begin
                        state <= S_LS_RD;
                        if (ifu_arvalid) starve_cnt <= starve_next;
                    end else if (ifu_arvalid) begin
                        state      <= S_IF_RD;
                        starve_cnt <= 4'd0;
                    end
                end
                S_IF_RD, S_LS_RD: begin
                    if (m_rvalid && m_rready) state <= S_IDLE;
                end
                S_LS_WR: begin
                    if (m_awvalid && m_awready) aw_done <= 1'b1;
                    if (m_wvalid && m_wready)   w_done  <= 1'b1;
                    if (m_bvalid && m_bready) begin
                        state   <= S_IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Only the granted master's channels are connected; everything else is held at zero.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = 2'd0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = 32'd0;
        lsu_rresp   = 2'd0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'd0;
        lsu_bvalid  = 1'b0;
        m_araddr    = 32'd0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awaddr    = 32'd0;
        m_awvalid   = 1'b0;
        m_wdata     = 32'd0;
        m_wstrb     = 4'd0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        case (state)
            S_IF_RD: begin
                m_araddr    = ifu_araddr;
                m_arvalid   = ifu_arvalid;
                ifu_arready = m_arready;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
                ifu_rvalid  = m_rvalid;
                m_rready    = ifu_rready;
            end
            S_LS_RD: begin
                m_araddr    = lsu_araddr;
                m_arvalid   = lsu_arvalid;
                lsu_arready = m_arready;
                lsu_rdata   = m_rdata;
                lsu_rresp   = m_rresp;
                lsu_rvalid  = m_rvalid;
                m_rready    = lsu_rready;
            end
            S_LS_WR: begin
                m_awaddr    = lsu_awaddr;
                m_awvalid   = lsu_awvalid && !aw_done;
                lsu_awready = m_awready;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                m_wvalid    = lsu_wvalid && !w_done;
                lsu_wready  = m_wready;
                lsu_bresp   = m_bresp;
                lsu_bvalid  = m_bvalid;
                m_bready    = lsu_bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Bench for the two-master AXI-Lite arbiter: the bench plays both masters and the slave,
// and predicts each grant from the priority and starvation rules.
module tb_ysyx_24100006_axi_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int W_NONE = 0;
    localparam int W_IF   = 1;
    localparam int W_RD   = 2;
    localparam int W_WR   = 3;

    logic        clk;
    logic        reset;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic        lsu_awready;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid;
    logic        lsu_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    ysyx_24100006_axi_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          model_starve = 0;
    bit          if_pend, rd_pend, wr_pend;
    logic [31:0] if_addr, rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;

    function automatic logic [255:0] all_out();
        return 256'({ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
                     lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
                     lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
                     m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
                     m_wdata, m_wstrb, m_wvalid, m_bready});
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive_masters(input int w, input bit a_d, input bit w_d);
        ifu_arvalid = if_pend && !(w == W_IF && a_d);
        lsu_arvalid = rd_pend && !(w == W_RD && a_d);
        lsu_awvalid = wr_pend && !(w == W_WR && a_d);
        lsu_wvalid  = wr_pend && !(w == W_WR && w_d);
        ifu_araddr  = if_addr;
        lsu_araddr  = rd_addr;
        lsu_awaddr  = wr_addr;
        lsu_wdata   = wr_data;
        lsu_wstrb   = wr_strb;
    endtask

    // One arbitration round, entered at the falling edge of an idle cycle.
    task automatic applyStimulus(output int obs_win);
        int   w;
        bit   a_d, w_d, fin, rv_hold, bv_hold;
        logic rd_ready;
        drive_masters(W_NONE, 1'b0, 1'b0);
        m_arready = rbit(); m_rvalid = rbit(); m_rdata = $urandom; m_rresp = 2'($urandom);
        m_awready = rbit(); m_wready = rbit(); m_bvalid = rbit(); m_bresp = 2'($urandom);
        ifu_rready = rbit(); lsu_rready = rbit(); lsu_bready = rbit();
        #1;
        checkOutput("idle_quiet", all_out(), '0);
        if (if_pend && model_starve == STARVE_LIMIT) w = W_IF;
        else if (wr_pend) w = W_WR;
        else if (rd_pend) w = W_RD;
        else if (if_pend) w = W_IF;
        else w = W_NONE;
        if (w == W_IF) model_starve = 0;
        else if (w != W_NONE && if_pend && model_starve < STARVE_LIMIT) model_starve++;
        obs_win = W_NONE;
        a_d = 0; w_d = 0; fin = 0; rv_hold = 0; bv_hold = 0;
        @(negedge clk);
        if (w == W_NONE) return;
        for (int cyc = 0; cyc < 16 && !fin; cyc++) begin
            drive_masters(w, a_d, w_d);
            ifu_rready = (cyc >= 8) || rbit();
            lsu_rready = (cyc >= 8) || rbit();
            lsu_bready = (cyc >= 8) || rbit();
            if (w == W_WR) begin
                m_awready = (cyc >= 3) || rbit();
                m_wready  = (cyc >= 3) || rbit();
                if (!bv_hold) begin
                    m_bvalid = a_d && w_d && ((cyc >= 6) || rbit());
                    m_bresp  = 2'($urandom);
                end
                m_arready = rbit(); m_rvalid = rbit(); m_rdata = $urandom; m_rresp = 2'($urandom);
            end else begin
                m_arready = (cyc >= 3) || rbit();
                if (!rv_hold) begin
                    m_rvalid = a_d && ((cyc >= 6) || rbit());
                    m_rdata  = $urandom;
                    m_rresp  = 2'($urandom);
                end
                m_awready = rbit(); m_wready = rbit(); m_bvalid = rbit(); m_bresp = 2'($urandom);
            end
            #1;
            if (cyc == 0) begin
                if (m_awvalid) obs_win = W_WR;
                else if (m_arvalid && m_araddr[31:28] == 4'h3) obs_win = W_IF;
                else if (m_arvalid) obs_win = W_RD;
                checkOutput("grant", 256'(obs_win), 256'(w));
            end
            case (w)
                W_IF: begin
                    checkOutput("if_fwd",
                        256'({m_arvalid, m_araddr, m_rready, ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp}),
                        256'({!a_d, if_addr, ifu_rready, m_arready, m_rvalid, m_rdata, m_rresp}));
                    checkOutput("if_gate",
                        256'({lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid, lsu_awready, lsu_wready,
                              lsu_bresp, lsu_bvalid, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready}), '0);
                end
                W_RD: begin
                    checkOutput("rd_fwd",
                        256'({m_arvalid, m_araddr, m_rready, lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp}),
                        256'({!a_d, rd_addr, lsu_rready, m_arready, m_rvalid, m_rdata, m_rresp}));
                    checkOutput("rd_gate",
                        256'({ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, lsu_awready, lsu_wready,
                              lsu_bresp, lsu_bvalid, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready}), '0);
                end
                default: begin
                    checkOutput("wr_fwd",
                        256'({m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
                              lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp}),
                        256'({!a_d, wr_addr, !w_d, wr_data, wr_strb, lsu_bready,
                              m_awready, m_wready, m_bvalid, m_bresp}));
                    checkOutput("wr_gate",
                        256'({ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, lsu_arready, lsu_rdata,
                              lsu_rresp, lsu_rvalid, m_araddr, m_arvalid, m_rready}), '0);
                end
            endcase
            if (w == W_WR) begin
                if (m_bvalid && lsu_bready) fin = 1;
                bv_hold = m_bvalid;
                if (m_awready) a_d = 1;
                if (m_wready) w_d = 1;
            end else begin
                rd_ready = (w == W_IF) ? ifu_rready : lsu_rready;
                if (m_rvalid && rd_ready) fin = 1;
                rv_hold = m_rvalid;
                if (m_arready) a_d = 1;
            end
            @(negedge clk);
        end
        checkOutput("round_done", 256'(fin), 256'(1));
        case (w)
            W_IF:    if_pend = 0;
            W_RD:    rd_pend = 0;
            default: wr_pend = 0;
        endcase
    endtask

    int obs;
    int rd_grants;
    bit starved_done;

    initial begin
        if_pend = 0; rd_pend = 0; wr_pend = 0;
        if_addr = 32'h3000_0000; rd_addr = 32'h8000_0000; wr_addr = 32'ha000_0000;
        wr_data = 32'h0; wr_strb = 4'h0;
        reset = 1'b1;
        ifu_araddr = 32'h3000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        lsu_araddr = 32'h8000_0004; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        lsu_awaddr = 32'ha000_0008; lsu_awvalid = 1'b1; lsu_wdata = 32'hdead_beef;
        lsu_wstrb = 4'hf; lsu_wvalid = 1'b1; lsu_bready = 1'b1;
        m_arready = 1'b1; m_rdata = 32'h1234_5678; m_rresp = 2'b10; m_rvalid = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b11; m_bvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_quiet", all_out(), '0);

        // IFU-only fetch straight out of reset
        @(negedge clk);
        reset = 1'b0;
        if_pend = 1; if_addr = 32'h3000_0000;
        applyStimulus(obs);
        checkOutput("ifu_only", 256'(obs), 256'(W_IF));

        // Simultaneous IFU read and LSU write: write first, then the fetch
        if_pend = 1; if_addr = {4'h3, 28'($urandom)};
        wr_pend = 1; wr_addr = {4'ha, 28'($urandom)}; wr_data = $urandom; wr_strb = 4'($urandom);
        applyStimulus(obs);
        checkOutput("sim_wr_first", 256'(obs), 256'(W_WR));
        applyStimulus(obs);
        checkOutput("sim_if_second", 256'(obs), 256'(W_IF));

        // Reset in the middle of an IFU read after the address handshake
        if_pend = 1; if_addr = 32'h3000_0000;
        drive_masters(W_NONE, 1'b0, 1'b0);
        ifu_rready = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0;
        m_wready = 1'b0; m_bvalid = 1'b0;
        @(negedge clk);
        m_arready = 1'b1;
        #1;
        checkOutput("rst_grant", 256'({m_arvalid, m_araddr}), 256'({1'b1, 32'h3000_0000}));
        @(negedge clk);
        ifu_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h0000_0413; m_rresp = 2'b00;
        reset = 1'b1;
        #1;
        checkOutput("rst_fwd", 256'({ifu_rvalid, ifu_rdata}), 256'({1'b1, 32'h0000_0413}));
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_clear", all_out(), '0);
        model_starve = 0;
        if_pend = 1; if_addr = {4'h3, 28'($urandom)};
        applyStimulus(obs);
        checkOutput("rst_regrant", 256'(obs), 256'(W_IF));

        // Back-to-back LSU reads against a waiting fetch
        if_pend = 1; if_addr = {4'h3, 28'($urandom)};
        rd_grants = 0; starved_done = 0;
        for (int k = 0; k < 20 && !starved_done; k++) begin
            if (!rd_pend) begin
                rd_pend = 1; rd_addr = {4'h8, 28'($urandom)};
            end
            applyStimulus(obs);
            if (obs == W_IF) starved_done = 1;
            else if (obs == W_RD) rd_grants++;
        end
        checkOutput("starve_grants", 256'(rd_grants), 256'(STARVE_LIMIT));

        // Random traffic from both masters
        for (int r = 0; r < 60; r++) begin
            if (!if_pend && rbit()) begin
                if_pend = 1; if_addr = {4'h3, 28'($urandom)};
            end
            if (!rd_pend && rbit()) begin
                rd_pend = 1; rd_addr = {4'h8, 28'($urandom)};
            end
            if (!wr_pend && ($urandom_range(0, 3) == 0)) begin
                wr_pend = 1; wr_addr = {4'ha, 28'($urandom)};
                wr_data = $urandom; wr_strb = 4'($urandom);
            end
            applyStimulus(obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
